// File: rtl/fifo_rd_stream_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_skid
//
// Purpose:
//   Read-side adapter that sits directly after a synchronous FIFO with a
//   show-ahead head word (fifo_ne / fifo_rd_data / fifo_re). It turns that
//   interface into a valid/ready stream whose data comes straight from a
//   register. A two-entry skid buffer (head + tail) keeps one word per clock
//   flowing.
//
//   fifo_re is computed only from registered occupancy and the FIFO/enable/
//   flush controls. It never looks at out_ready, so the sink's ready does not
//   ripple combinationally back into the FIFO. The cost of this is that a
//   word may already be in flight when the sink stalls; the tail register
//   absorbs it.
//
// Ports:
//   clk           in   1          Rising-edge clock for all state.
//   reset         in   1          Synchronous, active-high reset.
//   enable        in   1          Clock enable; low freezes all state.
//   flush         in   1          Synchronous discard of buffered words.
//   fifo_ne       in   1          Upstream FIFO not empty.
//   fifo_rd_data  in   DATAWIDTH  Upstream FIFO head word (show-ahead).
//   fifo_re       out  1          Pop the upstream FIFO head this cycle.
//   out_data      out  DATAWIDTH  Stream data (head buffer entry).
//   out_valid     out  1          Stream data valid.
//   out_ready     in   1          Sink accepts out_data this cycle.
//   occ           out  2          Buffer occupancy, 0..2.
// ---------------------------------------------------------------------------
module fifo_rd_stream_skid #(
  parameter int DATAWIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_ne,
  input  logic [DATAWIDTH-1:0] fifo_rd_data,
  output logic                 fifo_re,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           occ
);

  // Occupancy doubles as the FSM state; encoding equals the word count so
  // occ can be driven straight from the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } countState_e;

  countState_e           count_q, count_d;
  logic [DATAWIDTH-1:0]  head_q,  head_d;
  logic [DATAWIDTH-1:0]  tail_q,  tail_d;

  logic push;
  logic pop;

  // Handshake terms. push depends only on registered occupancy and the
  // upstream/control inputs, never on out_ready. Both push and out_valid are
  // also held low during reset so that no FIFO pop or sink transfer happens
  // in a cycle whose effect the reset would throw away.
  always_comb begin
    push      = !reset && enable && !flush && fifo_ne && (count_q != FULL);
    out_valid = !reset && enable && (count_q != EMPTY);
    pop       = out_valid && out_ready;
  end

  assign fifo_re  = push;
  assign out_data = head_q;
  assign occ      = count_q;

  // Next-state logic for the skid buffer. The head register is always the
  // word being presented; the tail only ever holds the single word that was
  // already popped from the FIFO when the sink stalled. Simultaneous push and
  // pop in ONE replaces the head directly, which is what gives full-rate
  // streaming through a single register. FULL never pushes, so on a pop the
  // tail simply moves up into the head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (enable) begin
      if (flush) begin
        count_d = EMPTY;
      end else begin
        case (count_q)
          EMPTY: begin
            if (push) begin
              head_d  = fifo_rd_data;
              count_d = ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head_d = fifo_rd_data;
            end else if (push) begin
              tail_d  = fifo_rd_data;
              count_d = FULL;
            end else if (pop) begin
              count_d = EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              head_d  = tail_q;
              count_d = ONE;
            end
          end
          default: begin
            count_d = EMPTY;
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset. Reset clears the data registers
  // as well so out_data reads zero until the first word is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_skid.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream_skid
//
// Purpose:
//   Self-checking bench for fifo_rd_stream_skid. The upstream FIFO is a
//   queue of words; the skid buffer is modelled as a queue of at most two
//   words with the stream handshake rules applied per cycle. Directed
//   scenarios (reset, streaming, backpressure, flush, enable gating) are
//   followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream_skid;

  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          fifo_ne;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_re;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occ;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Upstream FIFO contents, buffered words and words the sink accepted.
  logic [DW-1:0] srcQ[$];
  logic [DW-1:0] bufQ[$];
  logic [DW-1:0] acceptedQ[$];
  bit            modelValid = 1'b0;
  int            reCount    = 0;

  // Outputs observed in the most recent cycle, before its clock edge.
  logic          lastRe;
  logic          lastValid;
  logic [1:0]    lastOcc;
  logic [DW-1:0] lastData;

  fifo_rd_stream_skid #(.DATAWIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .fifo_ne      (fifo_ne),
    .fifo_rd_data (fifo_rd_data),
    .fifo_re      (fifo_re),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .occ          (occ)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs
  // against the model, then advance the model at the rising edge.
  task automatic applyStimulus(input bit rst, input bit en, input bit fl,
                               input bit rdy, input bit gate);
    bit expRe, expValid, popE;
    @(negedge clk);
    reset        = rst;
    enable       = en;
    flush        = fl;
    out_ready    = rdy;
    fifo_ne      = gate && (srcQ.size() > 0);
    fifo_rd_data = (srcQ.size() > 0) ? srcQ[0] : '0;
    #1;
    expRe    = !rst && en && !fl && fifo_ne && (bufQ.size() < 2);
    expValid = !rst && en && (bufQ.size() > 0);
    popE     = expValid && rdy;

    checkOutput("fifo_re", {31'd0, fifo_re}, {31'd0, expRe});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
    if (modelValid) begin
      checkOutput("occ", {30'd0, occ}, bufQ.size());
    end
    if (expValid) begin
      checkOutput("out_data", {14'd0, out_data}, {14'd0, bufQ[0]});
    end

    lastRe    = fifo_re;
    lastValid = out_valid;
    lastOcc   = occ;
    lastData  = out_data;
    if (fifo_re === 1'b1) reCount++;
    if (popE && out_valid === 1'b1) acceptedQ.push_back(out_data);

    @(posedge clk);
    if (rst) begin
      bufQ.delete();
      modelValid = 1'b1;
    end else if (en) begin
      if (popE) void'(bufQ.pop_front());
      if (fl) begin
        bufQ.delete();
      end else if (expRe) begin
        bufQ.push_back(srcQ[0]);
        void'(srcQ.pop_front());
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic checkAccepted(input string tag, input logic [DW-1:0] exp[$]);
    checkOutput({tag, "_count"}, acceptedQ.size(), exp.size());
    for (int i = 0; i < exp.size() && i < acceptedQ.size(); i++) begin
      checkOutput({tag, "_word"}, {14'd0, acceptedQ[i]}, {14'd0, exp[i]});
    end
  endtask

  initial begin
    logic [DW-1:0] expWords[$];
    logic [DW-1:0] nextWord;
    bit rRst, rEn, rFl, rRdy, rGate;

    reset = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_ne = 1'b0; fifo_rd_data = '0;

    // Reset held two clocks with a non-empty FIFO.
    srcQ = '{18'h100};
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_re", {31'd0, lastRe}, 32'd0);
    checkOutput("reset_occ", {30'd0, lastOcc}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_first_re", {31'd0, lastRe}, 32'd1);
    checkOutput("reset_data_zero", {14'd0, lastData}, 32'd0);
    drain(3);

    // Full-rate streaming of eight words.
    acceptedQ.delete();
    reCount = 0;
    for (int i = 1; i <= 8; i++) srcQ.push_back(DW'(i));
    drain(10);
    expWords.delete();
    for (int i = 1; i <= 8; i++) expWords.push_back(DW'(i));
    checkAccepted("stream", expWords);
    checkOutput("stream_re_count", reCount, 32'd8);

    // Backpressure: sink stalls after accepting 0x10.
    acceptedQ.delete();
    srcQ = '{18'h10, 18'h11, 18'h12, 18'h13};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_occ", {30'd0, lastOcc}, 32'd2);
    checkOutput("bp_re", {31'd0, lastRe}, 32'd0);
    checkOutput("bp_data", {14'd0, lastData}, 32'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_data_hold", {14'd0, lastData}, 32'h11);
    drain(6);
    checkAccepted("bp", '{18'h10, 18'h11, 18'h12, 18'h13});

    // Flush with the buffer full.
    acceptedQ.delete();
    srcQ = '{18'h20, 18'h21, 18'h22};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_occ_before", {30'd0, lastOcc}, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_occ_after", {30'd0, lastOcc}, 32'd0);
    checkOutput("flush_valid_after", {31'd0, lastValid}, 32'd0);
    checkOutput("flush_re_after", {31'd0, lastRe}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_next_word", {14'd0, lastData}, 32'h22);
    drain(2);
    checkAccepted("flush", '{18'h22});

    // Enable gating with one word buffered.
    acceptedQ.delete();
    srcQ = '{18'h30};
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    srcQ.push_back(18'h31);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("en_valid_low", {31'd0, lastValid}, 32'd0);
      checkOutput("en_head_hold", {14'd0, lastData}, 32'h30);
    end
    drain(4);
    checkAccepted("enable", '{18'h30, 18'h31});

    // Randomized run against the model.
    nextWord = 18'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      while (srcQ.size() < 4) begin
        srcQ.push_back(nextWord);
        nextWord = nextWord + 1'b1;
      end
      rRst  = ($urandom_range(499) == 0);
      rEn   = ($urandom_range(7) != 0);
      rFl   = ($urandom_range(29) == 0);
      rRdy  = ($urandom_range(1) == 1);
      rGate = ($urandom_range(9) < 7);
      applyStimulus(rRst, rEn, rFl, rRdy, rGate);
      if (lastRe === 1'b1) begin
        checkOutput("rand_re_not_full", {31'd0, (lastOcc == 2'd2)}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
